// File: rtl/mlp_ctrl_pkg.sv
// Shared types and defaults for the printed-MLP inference sequencer.
package mlp_ctrl_pkg;

    localparam int IN_W_DEF   = 36;
    localparam int OUT_W_DEF  = 2;
    localparam int CNT_W_DEF  = 8;
    localparam int STAT_W_DEF = 16;

    // Controller phases: wait for a sample, let the MLP settle,
    // take the second class sample, then present the result.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        OUT    = 2'd3
    } state_e;

    typedef logic [OUT_W_DEF-1:0] class_t;

endpackage

// File: rtl/mlp_sat_counter.sv
// Saturating event counter with a synchronous clear that beats the increment.
module mlp_sat_counter #(
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_i,
    input  logic              clr_i,
    output logic [STAT_W-1:0] count_o
);

    localparam logic [STAT_W-1:0] ONE = {{(STAT_W-1){1'b0}}, 1'b1};

    logic [STAT_W-1:0] count_q;
    logic [STAT_W-1:0] count_d;

    // Next count: clear first, otherwise step unless already pinned at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + ONE;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/mlp_infer_ctrl.sv
// Sequencer around a combinational printed-MLP classifier: holds a sample on
// the MLP input for a settle window, samples the class twice to expose
// instability, and hands the result out on a valid/ready channel.
module mlp_infer_ctrl
    import mlp_ctrl_pkg::*;
#(
    parameter int IN_W   = IN_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int STAT_W = STAT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    input  logic [CNT_W-1:0]  cfg_settle,
    output logic [IN_W-1:0]   mlp_inp,
    input  logic [OUT_W-1:0]  mlp_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_class,
    output logic              out_mismatch,
    output logic              busy,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stat_samples,
    output logic [STAT_W-1:0] stat_mismatch
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   s0_q, s0_d;
    logic [IN_W-1:0]    mlp_inp_q, mlp_inp_d;
    logic [OUT_W-1:0]   out_class_q, out_class_d;
    logic               out_mismatch_q, out_mismatch_d;

    logic [CNT_W-1:0]   settle_eff;
    logic               samples_inc;
    logic               mismatch_inc;

    // A zero settle request still needs one cycle before the first sample.
    assign settle_eff = (cfg_settle == '0) ? CNT_ONE : cfg_settle;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: strictly one sample in flight, no overlap.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)        state_d = SETTLE;
            SETTLE:  if (cnt_q == CNT_ONE) state_d = CHECK;
            CHECK:                        state_d = OUT;
            OUT:     if (out_ready)       state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        in_ready     = (state_q == IDLE);
        out_valid    = (state_q == OUT);
        busy         = (state_q != IDLE);
        samples_inc  = (state_q == CHECK);
        mismatch_inc = (state_q == CHECK) && (s0_q != mlp_out);
    end

    // Datapath next values; the MLP drive is only rewritten on acceptance so
    // the netlist never sees spurious input transitions.
    always_comb begin
        cnt_d          = cnt_q;
        s0_d           = s0_q;
        mlp_inp_d      = mlp_inp_q;
        out_class_d    = out_class_q;
        out_mismatch_d = out_mismatch_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mlp_inp_d = in_data;
                    cnt_d     = settle_eff;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    s0_d = mlp_out;
                end
            end
            CHECK: begin
                out_class_d    = mlp_out;
                out_mismatch_d = (s0_q != mlp_out);
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q          <= '0;
            s0_q           <= '0;
            mlp_inp_q      <= '0;
            out_class_q    <= '0;
            out_mismatch_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            s0_q           <= s0_d;
            mlp_inp_q      <= mlp_inp_d;
            out_class_q    <= out_class_d;
            out_mismatch_q <= out_mismatch_d;
        end
    end

    assign mlp_inp      = mlp_inp_q;
    assign out_class    = out_class_q;
    assign out_mismatch = out_mismatch_q;

    mlp_sat_counter #(.STAT_W(STAT_W)) u_cnt_samples (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (samples_inc),
        .clr_i   (stat_clr),
        .count_o (stat_samples)
    );

    mlp_sat_counter #(.STAT_W(STAT_W)) u_cnt_mismatch (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (mismatch_inc),
        .clr_i   (stat_clr),
        .count_o (stat_mismatch)
    );

endmodule

// File: tb/tb_mlp_infer_ctrl.sv
// Self-checking bench for mlp_infer_ctrl. A second instance with 3-bit
// statistics shares all stimulus so counter saturation is reachable quickly.
module tb_mlp_infer_ctrl;

    localparam int IN_W  = 36;
    localparam int OUT_W = 2;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [IN_W-1:0]  in_data;
    logic [CNT_W-1:0] cfg_settle;
    logic [OUT_W-1:0] mlp_out;
    logic             out_ready;
    logic             stat_clr;

    logic             in_ready, out_valid, out_mismatch, busy;
    logic [IN_W-1:0]  mlp_inp;
    logic [OUT_W-1:0] out_class;
    logic [15:0]      stat_samples, stat_mismatch;

    logic             sIn_ready, sOut_valid, sOut_mismatch, sBusy;
    logic [IN_W-1:0]  sMlp_inp;
    logic [OUT_W-1:0] sOut_class;
    logic [2:0]       sStat_samples, sStat_mismatch;

    int checks   = 0;
    int failures = 0;

    // Reference statistics: plain saturating arithmetic on completed runs.
    int unsigned expSamples   = 0;
    int unsigned expMismatch  = 0;
    int unsigned expSSamples  = 0;
    int unsigned expSMismatch = 0;

    always #5 clk = ~clk;

    mlp_infer_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .cfg_settle(cfg_settle), .mlp_inp(mlp_inp),
        .mlp_out(mlp_out), .out_valid(out_valid), .out_ready(out_ready),
        .out_class(out_class), .out_mismatch(out_mismatch), .busy(busy),
        .stat_clr(stat_clr), .stat_samples(stat_samples),
        .stat_mismatch(stat_mismatch)
    );

    mlp_infer_ctrl #(.STAT_W(3)) dutSmall (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sIn_ready),
        .in_data(in_data), .cfg_settle(cfg_settle), .mlp_inp(sMlp_inp),
        .mlp_out(mlp_out), .out_valid(sOut_valid), .out_ready(out_ready),
        .out_class(sOut_class), .out_mismatch(sOut_mismatch), .busy(sBusy),
        .stat_clr(stat_clr), .stat_samples(sStat_samples),
        .stat_mismatch(sStat_mismatch)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic modelStats(input bit mis, input bit clr);
        if (clr) begin
            expSamples = 0; expMismatch = 0; expSSamples = 0; expSMismatch = 0;
        end else begin
            expSamples  = (expSamples  >= 65535) ? 65535 : expSamples + 1;
            expSSamples = (expSSamples >= 7)     ? 7     : expSSamples + 1;
            if (mis) begin
                expMismatch  = (expMismatch  >= 65535) ? 65535 : expMismatch + 1;
                expSMismatch = (expSMismatch >= 7)     ? 7     : expSMismatch + 1;
            end
        end
    endtask

    // One full transaction. mode 0: mlp_out constant v0; mode 1: v0 up to the
    // first sample edge then v1 at the second; mode 2: random every cycle.
    task automatic doTxn(input logic [IN_W-1:0] data, input logic [CNT_W-1:0] cfg,
                         input int mode, input logic [1:0] v0, input logic [1:0] v1,
                         input int bp, input bit clrAtCheck);
        int         s;
        logic [1:0] s0e;
        logic [1:0] ce;
        bit         mis;
        s   = (cfg == 0) ? 1 : int'(cfg);
        s0e = 2'b00;
        ce  = 2'b00;

        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("[TB] FAIL accept_ready got=%b exp=1", in_ready);
        end
        in_valid  = 1'b1;
        in_data   = data;
        cfg_settle = cfg;
        mlp_out   = (mode == 2) ? 2'($urandom_range(0, 3)) : v0;
        out_ready = (bp == 0);
        tick();
        in_valid   = 1'b0;
        in_data    = {4'($urandom), 32'($urandom)};
        cfg_settle = 8'($urandom_range(1, 255));

        checks++;
        if (mlp_inp !== data || busy !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL accepted got=%h/%b/%b exp=%h/1/0", mlp_inp, busy, in_ready, data);
        end

        for (int k = 1; k <= s + 1; k++) begin
            if (mode == 0)      mlp_out = v0;
            else if (mode == 1) mlp_out = (k <= s) ? v0 : v1;
            else                mlp_out = 2'($urandom_range(0, 3));
            if (k == s)     s0e = mlp_out;
            if (k == s + 1) ce  = mlp_out;
            stat_clr = clrAtCheck && (k == s + 1);
            tick();
            stat_clr = 1'b0;
            if (k <= s) begin
                checks++;
                if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL early_valid k=%0d got=%b/%b exp=0/0", k, out_valid, in_ready);
                end
            end
        end

        mis = (s0e != ce);
        modelStats(mis, clrAtCheck);

        checks++;
        if (out_valid !== 1'b1 || out_class !== ce || out_mismatch !== mis) begin
            failures++;
            $display("[TB] FAIL result got=%b/%0d/%b exp=1/%0d/%b", out_valid, out_class, out_mismatch, ce, mis);
        end
        checks++;
        if (stat_samples !== 16'(expSamples) || stat_mismatch !== 16'(expMismatch)) begin
            failures++;
            $display("[TB] FAIL stats got=%0d/%0d exp=%0d/%0d", stat_samples, stat_mismatch, expSamples, expMismatch);
        end
        checks++;
        if (sStat_samples !== 3'(expSSamples) || sStat_mismatch !== 3'(expSMismatch) ||
            sOut_valid !== 1'b1 || sOut_class !== ce) begin
            failures++;
            $display("[TB] FAIL small_stats got=%0d/%0d/%b/%0d exp=%0d/%0d/1/%0d",
                     sStat_samples, sStat_mismatch, sOut_valid, sOut_class, expSSamples, expSMismatch, ce);
        end

        for (int i = 0; i < bp; i++) begin
            in_valid = 1'b1;
            in_data  = {4'($urandom), 32'($urandom)};
            mlp_out  = 2'($urandom_range(0, 3));
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_class !== ce || out_mismatch !== mis ||
                in_ready !== 1'b0 || mlp_inp !== data) begin
                failures++;
                $display("[TB] FAIL backpressure i=%0d got=%b/%0d/%b/%b/%h exp=1/%0d/%b/0/%h",
                         i, out_valid, out_class, out_mismatch, in_ready, mlp_inp, ce, mis, data);
            end
        end

        in_valid  = 1'b1;
        in_data   = {4'($urandom), 32'($urandom)};
        mlp_out   = 2'($urandom_range(0, 3));
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_class !== ce ||
            out_mismatch !== mis || mlp_inp !== data || sIn_ready !== 1'b1 || sMlp_inp !== data) begin
            failures++;
            $display("[TB] FAIL handshake got=%b/%b/%b/%0d/%b/%h exp=0/1/0/%0d/%b/%h",
                     out_valid, in_ready, busy, out_class, out_mismatch, mlp_inp, ce, mis, data);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (mlp_inp !== '0 || out_class !== '0 || out_mismatch !== 1'b0 || out_valid !== 1'b0 ||
            busy !== 1'b0 || in_ready !== 1'b1 || stat_samples !== '0 || stat_mismatch !== '0) begin
            failures++;
            $display("[TB] FAIL reset got=%h/%0d/%b/%b/%b/%b/%0d/%0d exp=0/0/0/0/0/1/0/0",
                     mlp_inp, out_class, out_mismatch, out_valid, busy, in_ready, stat_samples, stat_mismatch);
        end
        checks++;
        if (sBusy !== 1'b0 || sOut_mismatch !== 1'b0 || sStat_samples !== '0) begin
            failures++;
            $display("[TB] FAIL reset_small got=%b/%b/%0d exp=0/0/0", sBusy, sOut_mismatch, sStat_samples);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        doTxn(36'h123456789, 8'd3, 0, 2'b01, 2'b01, 0, 1'b0);
    endtask

    task automatic test_settle_zero();
        doTxn({4'($urandom), 32'($urandom)}, 8'd0, 0, 2'b10, 2'b10, 0, 1'b0);
    endtask

    task automatic test_mismatch();
        doTxn({4'($urandom), 32'($urandom)}, 8'd2, 1, 2'b00, 2'b01, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        doTxn({4'($urandom), 32'($urandom)}, 8'd4, 2, 2'b00, 2'b00, 10, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 8; n++) begin
            doTxn({4'($urandom), 32'($urandom)}, 8'($urandom_range(0, 5)), 2,
                  2'b00, 2'b00, (n % 3 == 2) ? int'($urandom_range(1, 3)) : 0, 1'b0);
        end
    endtask

    task automatic test_stat_clr();
        doTxn({4'($urandom), 32'($urandom)}, 8'd2, 1, 2'b11, 2'b00, 0, 1'b1);
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 10; n++) begin
            doTxn({4'($urandom), 32'($urandom)}, 8'd1, 1, 2'b01, 2'b10, 0, 1'b0);
        end
        checks++;
        if (sStat_samples !== 3'b111 || sStat_mismatch !== 3'b111) begin
            failures++;
            $display("[TB] FAIL saturate got=%0d/%0d exp=7/7", sStat_samples, sStat_mismatch);
        end
    endtask

    task automatic test_reset_mid();
        in_valid   = 1'b1;
        in_data    = 36'hABCDE0123;
        cfg_settle = 8'd5;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (mlp_inp !== '0 || out_class !== '0 || out_mismatch !== 1'b0 || out_valid !== 1'b0 ||
            busy !== 1'b0 || in_ready !== 1'b1 || stat_samples !== '0 || stat_mismatch !== '0) begin
            failures++;
            $display("[TB] FAIL reset_mid got=%h/%0d/%b/%b/%b/%b/%0d/%0d exp=0/0/0/0/0/1/0/0",
                     mlp_inp, out_class, out_mismatch, out_valid, busy, in_ready, stat_samples, stat_mismatch);
        end
        modelStats(1'b0, 1'b1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_mid_idle i=%0d got=%b/%b exp=0/0", i, out_valid, busy);
            end
        end
        doTxn({4'($urandom), 32'($urandom)}, 8'd1, 0, 2'b11, 2'b11, 0, 1'b0);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        cfg_settle = '0;
        mlp_out    = '0;
        out_ready  = 1'b1;
        stat_clr   = 1'b0;
        test_reset();
        test_basic();
        test_settle_zero();
        test_mismatch();
        test_backpressure();
        test_back_to_back();
        test_stat_clr();
        test_saturation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mlp_infer_ctrl.md
Name: mlp_infer_ctrl

Overview:
- Sequencer wrapping the combinational printed-MLP classifier netlist (36-bit packed input, 9 features x 4 bit; 2-bit argmax class out).
- Accepts one sample per valid/ready handshake and holds it stable on the MLP input for a programmable settle window.
- Double-samples the class output to flag timing/fault instability, then presents the result on an output valid/ready channel.
- Keeps saturating sample and mismatch statistics for fault-analysis campaigns.

Parameters:
IN_W, 36, packed feature-vector width driven to the MLP
OUT_W, 2, class-index width returned by the MLP
CNT_W, 8, width of the settle counter and cfg_settle
STAT_W, 16, width of each statistics counter

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  sample offered
in_ready  out  1  controller can accept a sample
in_data  in  IN_W  packed features
cfg_settle  in  CNT_W  settle cycles before the first sample; 0 treated as 1
mlp_inp  out  IN_W  registered drive to the MLP input
mlp_out  in  OUT_W  MLP class output (combinational, unregistered)
out_valid  out  1  result available
out_ready  in  1  consumer takes result
out_class  out  OUT_W  captured class
out_mismatch  out  1  the two output samples differed
busy  out  1  state != IDLE
stat_clr  in  1  synchronous clear of the statistics
stat_samples  out  STAT_W  completed inferences, saturating
stat_mismatch  out  STAT_W  inferences with mismatch, saturating

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: state IDLE; mlp_inp, out_class, out_mismatch, out_valid, both stat counters and the internal s0/cnt registers are all 0. in_ready is 1 after reset.
- FSM states: IDLE, SETTLE, CHECK, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: mlp_inp<=in_data; cnt<=max(cfg_settle,1); go SETTLE.
  - cfg_settle is sampled only at acceptance; later changes do not affect the sample in flight.
- SETTLE:
  - cnt decrements each cycle.
  - On the edge where cnt==1: s0<=mlp_out; go CHECK.
- CHECK:
  - out_class<=mlp_out (the later sample is authoritative).
  - out_mismatch<=(s0!=mlp_out).
  - stat_samples increments; stat_mismatch increments if there is a mismatch.
  - Go OUT.
- OUT:
  - out_valid=1; out_class and out_mismatch are held stable until out_ready.
  - On out_valid&out_ready: go IDLE; out_valid drops the next cycle.
- in_ready=1 only in IDLE. There is no overlap and no skid buffer.
- Latency: with acceptance at edge E0 and effective settle S, out_valid is high after edge E0+S+1.
- Minimum period per sample: S+3 cycles with out_ready held high.
- mlp_inp is never cleared after use. It holds the last accepted sample until the next acceptance, so the MLP never sees spurious transitions.
- out_class and out_mismatch retain their values after the handshake until the next CHECK.
- Counters saturate at all-ones and do not wrap.
- stat_clr zeroes both counters the next edge. If it coincides with an increment, the clear wins and the result is 0.
- Reset mid-operation: the FSM aborts to IDLE, no result is produced, and counters return to 0.
- in_valid while busy is ignored (in_ready=0). The source must hold in_valid and in_data until accepted.

Decomposition:
- Package mlp_ctrl_pkg contains:
  - state enum {IDLE,SETTLE,CHECK,OUT};
  - IN_W/OUT_W defaults;
  - typedef for the class index.
- One sub-module, mlp_sat_counter (STAT_W, inc, clr, count, clr priority), instanced twice.

Test Plan:
- Reset, then in_data=36'h123456789, cfg_settle=3, out_ready=1, mlp_out constant 2'b01:
  - mlp_inp=36'h123456789 after the accept edge;
  - out_valid after edge E0+4 with out_class=1, out_mismatch=0;
  - stat_samples=1.
- cfg_settle=0 -> behaves as 1: out_valid after edge E0+2.
- Same-sample mismatch: cfg_settle=2, mlp_out=0 at the s0 edge and 1 at the CHECK edge:
  - out_class=1, out_mismatch=1, stat_mismatch=1.
- Backpressure: hold out_ready=0 for 10 cycles.
  - out_valid, out_class and out_mismatch stay stable; in_ready=0.
  - A second in_valid is not accepted until the cycle after out_ready=1.
- Assert rst in SETTLE: all outputs 0, in_ready=1, no out_valid.
- With stat_samples preloaded to 16'hFFFF via 65535 runs (or forced), one more run keeps it at 16'hFFFF.
- stat_clr pulsed on the CHECK edge gives 0 for both counters.
